// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Purpose  : Turns one asynchronous, bouncy push-button into a clean
//            debounced level, a one-cycle press pulse (with optional
//            auto-repeat while the key is held) and a one-cycle release
//            pulse.
// Ports    : clk         - clock, rising edge
//            rst_n       - synchronous active-low reset
//            key_in      - raw key (asynchronous), 1 = pressed
//            repeat_en   - enables auto-repeat pulses while held
//            key_level   - debounced key state
//            key_pulse   - one cycle on accepted press and on each repeat
//            key_release - one cycle on accepted release
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int REPEAT_DELAY    = 100,
    parameter int REPEAT_PERIOD   = 25,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    input  logic repeat_en,
    output logic key_level,
    output logic key_pulse,
    output logic key_release
);

    localparam logic [1:0] c_idle         = 2'd0;
    localparam logic [1:0] c_press_wait   = 2'd1;
    localparam logic [1:0] c_held         = 2'd2;
    localparam logic [1:0] c_release_wait = 2'd3;

    // Timers compare against "value - 1" because the first stable sample
    // (the transition edge itself) loads the timer with 1.
    localparam logic [CNT_W-1:0] c_deb_last = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_dly_last = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] c_per_last = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    logic             r_sync1;
    logic             r_key_s;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] r_rpt_cnt;
    logic             r_first_done;
    logic             r_level;
    logic             r_pulse;
    logic             r_release;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_timer_nxt;
    logic [CNT_W-1:0] w_rpt_cnt_nxt;
    logic             w_first_done_nxt;
    logic             w_level_nxt;
    logic             w_pulse_nxt;
    logic             w_release_nxt;
    logic [CNT_W-1:0] w_rpt_thresh;

    // Two-flop synchronizer; only r_key_s is used downstream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_key_s <= 1'b0;
        end else begin
            r_sync1 <= key_in;
            r_key_s <= r_sync1;
        end
    end

    // First repeat waits the long delay, subsequent ones the short period.
    assign w_rpt_thresh = r_first_done ? c_per_last : c_dly_last;

    always_comb begin
        w_state_nxt      = r_state;
        w_timer_nxt      = r_timer;
        w_rpt_cnt_nxt    = r_rpt_cnt;
        w_first_done_nxt = r_first_done;
        w_level_nxt      = r_level;
        w_pulse_nxt      = 1'b0;
        w_release_nxt    = 1'b0;

        case (r_state)
            c_idle: begin
                if (r_key_s) begin
                    w_state_nxt = c_press_wait;
                    w_timer_nxt = c_one;
                end
            end

            c_press_wait: begin
                if (!r_key_s) begin
                    w_state_nxt = c_idle;
                end else if (r_timer == c_deb_last) begin
                    w_state_nxt      = c_held;
                    w_level_nxt      = 1'b1;
                    w_pulse_nxt      = 1'b1;
                    w_rpt_cnt_nxt    = '0;
                    w_first_done_nxt = 1'b0;
                end else begin
                    w_timer_nxt = r_timer + c_one;
                end
            end

            c_held: begin
                if (!r_key_s) begin
                    // Repeat counter is left untouched so a rejected
                    // release bounce only delays the next repeat.
                    w_state_nxt = c_release_wait;
                    w_timer_nxt = c_one;
                end else if (!repeat_en) begin
                    w_rpt_cnt_nxt    = '0;
                    w_first_done_nxt = 1'b0;
                end else if (r_rpt_cnt == w_rpt_thresh) begin
                    w_pulse_nxt      = 1'b1;
                    w_rpt_cnt_nxt    = '0;
                    w_first_done_nxt = 1'b1;
                end else begin
                    w_rpt_cnt_nxt = r_rpt_cnt + c_one;
                end
            end

            c_release_wait: begin
                if (r_key_s) begin
                    w_state_nxt = c_held;
                end else if (r_timer == c_deb_last) begin
                    w_state_nxt   = c_idle;
                    w_level_nxt   = 1'b0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_timer_nxt = r_timer + c_one;
                end
            end

            default: begin
                w_state_nxt = c_idle;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_idle;
            r_timer      <= '0;
            r_rpt_cnt    <= '0;
            r_first_done <= 1'b0;
            r_level      <= 1'b0;
            r_pulse      <= 1'b0;
            r_release    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_rpt_cnt    <= w_rpt_cnt_nxt;
            r_first_done <= w_first_done_nxt;
            r_level      <= w_level_nxt;
            r_pulse      <= w_pulse_nxt;
            r_release    <= w_release_nxt;
        end
    end

    assign key_level   = r_level;
    assign key_pulse   = r_pulse;
    assign key_release = r_release;

endmodule
`default_nettype wire

// File: doc/key_debounce.md
Name: key_debounce

Overview:
- Conditions one asynchronous, bouncy push-button input into clean single-cycle events.
- Feeds the 4-bit counter stage as its increment/enable source.
- Outputs:
  - a debounced level;
  - a one-cycle press pulse, with optional auto-repeat while the key is held;
  - a one-cycle release pulse.

Parameters:
- DEBOUNCE_CYCLES, 20: consecutive stable synchronized samples required to accept a press or a release. Legal range is at least 2.
- REPEAT_DELAY, 100: cycles from the initial press pulse to the first auto-repeat pulse. Legal range is at least 2.
- REPEAT_PERIOD, 25: cycles between successive auto-repeat pulses. Legal range is at least 2.
- CNT_W, 16: width of the internal timers. Every parameter above must be less than 2^CNT_W.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- key_in, input, 1: raw key, asynchronous to clk; 1 = pressed.
- repeat_en, input, 1: synchronous to clk; 1 enables auto-repeat pulses while held.
- key_level, output, 1: debounced key state.
- key_pulse, output, 1: one-cycle pulse on accepted press and on each auto-repeat.
- key_release, output, 1: one-cycle pulse on accepted release.

Behaviour:
- Reset (rst_n = 0 at a rising edge):
  - synchronizer flops, FSM, timers and all outputs are cleared;
  - state returns to IDLE; key_level, key_pulse and key_release are 0;
  - reset overrides everything, including mid-operation;
  - after reset, a still-held key must be fully re-debounced.
- Synchronizer: 2-flop chain on key_in; its second stage is key_s. All FSM decisions use key_s only.
- All outputs are registered. key_pulse and key_release are 0 in every cycle not named below.
- FSM states:
  - IDLE (key_level = 0):
    - key_s = 1 → go to PRESS_WAIT with timer = 1.
  - PRESS_WAIT (key_level = 0):
    - key_s = 0 → go to IDLE (glitch rejected, no output).
    - key_s = 1 and timer = DEBOUNCE_CYCLES-1 → go to HELD; set key_level = 1 and key_pulse = 1 on that same edge; clear rpt_cnt and the first_done flag.
    - Otherwise timer++.
  - HELD (key_level = 1):
    - key_s = 0 → go to RELEASE_WAIT with timer = 1; rpt_cnt is frozen.
    - Otherwise the auto-repeat rules below apply.
  - RELEASE_WAIT (key_level = 1):
    - key_s = 1 → return to HELD (release bounce rejected); rpt_cnt resumes from its frozen value.
    - key_s = 0 and timer = DEBOUNCE_CYCLES-1 → go to IDLE; set key_level = 0 and key_release = 1 on that edge.
    - Otherwise timer++.
- Auto-repeat (HELD only, key_s = 1):
  - repeat_en = 0: clear rpt_cnt and first_done.
  - repeat_en = 1:
    - the threshold is REPEAT_DELAY-1 if first_done = 0, else REPEAT_PERIOD-1;
    - when rpt_cnt = threshold: key_pulse = 1, rpt_cnt = 0, first_done = 1;
    - otherwise rpt_cnt++.
  - Timing result: the first repeat comes exactly REPEAT_DELAY cycles after the press pulse, then one every REPEAT_PERIOD cycles.
- Latency:
  - key_in stable high before edge 1 → key_pulse high in the cycle after edge DEBOUNCE_CYCLES+2.
  - Release is symmetric: key_release follows DEBOUNCE_CYCLES+2 edges after key_in falls.
- Timers never wrap; each is bounded by its parameter-derived thresholds.
- key_pulse and key_release are never high in the same cycle.

Test Plan (bench parameters DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3; edge n counted from first key_in change):
1. Clean press, repeat_en=0: key_in 0→1 before edge 1, held → key_pulse high for exactly one cycle after edge 6; key_level 1 from edge 6; no further pulses.
2. Bounce: key_in high for 3 cycles then low, repeated 5 times → key_pulse, key_release and key_level stay 0 throughout.
3. Auto-repeat: press held 30 cycles with repeat_en=1 → key_pulse after edges 6, 16, 19, 22, 25, 28, 31 and none in between; then release → key_release exactly once, 6 edges after key_in falls.
4. Release bounce: while HELD, key_in drops for 2 cycles then returns high → no key_release; key_level stays 1; repeat spacing is extended only by the frozen cycles.
5. Reset mid-hold: rst_n=0 for one edge while HELD with key_in still high → all outputs 0 next cycle; new key_pulse only after a full re-debounce (edge 6 relative to reset release).
6. repeat_en toggle: deassert after the first repeat, reassert 5 cycles later → first subsequent repeat occurs 10 cycles after reassertion, then every 3 cycles.
